// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first.
// One full-subtractor cell plus a borrow flop; one bit per clock, start/busy/done handshake.
// Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH.
// Backpressure: none; start is sampled only in IDLE and is otherwise ignored, never queued.
// Ports: clk, rst (sync, active-high); start, a, b, bin in; busy, done, diff, bout out.
// Optional macro SUB_OVERFLOW_EN adds output ovf (signed two's-complement overflow).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  // Counter reaches WIDTH on the final edge, so one extra bit beyond $clog2.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic br_next;
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // MSB cell: publish the completed result and its borrow.
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
`ifdef SUB_OVERFLOW_EN
          // br_q is the borrow into the MSB cell at this point.
          ovf_d   = br_q ^ br_next;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule
